dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep controller placed directly upstream of the DDS phase accumulator. It drives the 32-bit frequency tuning word, so the accumulator can run linear up-ramp, sawtooth or triangle sweeps instead of a fixed tone. Sweeps are configured by start/stop/step words and a per-step dwell count, and are started and aborted by single-cycle pulses. It runs in the DDS clock domain (PLL output).

Parameters:
FW_WIDTH, 32, tuning-word width; must equal the DDS accumulator width
DWELL_WIDTH, 24, width of dwell counter

Ports:
CLK  input  1  DDS clock
RST  input  1  asynchronous, active-high reset
START  input  1  single-cycle pulse that begins a sweep; honoured only in IDLE
ABORT  input  1  single-cycle pulse that stops the sweep; priority over START
START_FW  input  FW_WIDTH  first/lower tuning word
STOP_FW  input  FW_WIDTH  last/upper tuning word
STEP_FW  input  FW_WIDTH  increment per step
DWELL  input  DWELL_WIDTH  each tuning word is held DWELL+1 clocks
MODE  input  2  00 single up-ramp, 01 continuous sawtooth, 10 continuous triangle, 11 single triangle
FREQW  output  FW_WIDTH  tuning word to the DDS accumulator
FREQ_UPD  output  1  one-cycle pulse in the first cycle a new FREQW value is presented
BUSY  output  1  high while a sweep runs
DONE  output  1  one-cycle pulse when a single-shot sweep completes

Behaviour:
- Clock and reset: one clock (CLK); asynchronous, active-high reset (RST).
- Reset values: FREQW=0, FREQ_UPD=0, BUSY=0, DONE=0, state IDLE, direction up, dwell count 0. Reset mid-sweep has the same effect immediately.
- States:
  - IDLE: waits for START.
  - HOLD: counts down the dwell for the current word.
  - FINISH: one cycle; asserts DONE.
- Start:
  - START in IDLE at cycle t latches START_FW, STOP_FW, STEP_FW, DWELL and MODE. Later changes to these inputs are ignored until the next START.
  - At t+1: FREQW=START_FW, FREQ_UPD=1, BUSY=1, direction up, dwell count=DWELL.
- HOLD: the dwell count decrements each cycle. When the count is 0, the next cycle presents the next word (FREQ_UPD=1) and reloads DWELL. Every word is therefore held exactly DWELL+1 cycles.
- Up step:
  - next = FREQW + STEP_FW, computed FW_WIDTH+1 bits wide.
  - If next >= STOP_FW or the carry is set, FREQW = STOP_FW (clamp).
- At STOP_FW when its dwell ends:
  - mode 00: go to FINISH.
  - mode 01: reload START_FW.
  - modes 10/11: direction down; step from STOP_FW.
- Down step:
  - next = FREQW - STEP_FW; on borrow or next <= START_FW, FREQW = START_FW.
- At START_FW when its dwell ends while direction is down:
  - mode 11: go to FINISH.
  - mode 10: direction up; step from START_FW.
- FINISH: DONE=1 and BUSY=0 in the same cycle; FREQW holds its last value (STOP_FW for mode 00, START_FW for mode 11). Return to IDLE next cycle.
- Degenerate configuration (STEP_FW==0 or STOP_FW<=START_FW): present START_FW, hold one dwell, then FINISH in every mode. Continuous modes do not loop.
- ABORT: in any non-IDLE state, next cycle goes to IDLE with BUSY=0, DONE=0, FREQ_UPD=0, FREQW held. ABORT in IDLE is ignored. If ABORT and START coincide in IDLE, ABORT wins and no sweep starts.
- START while BUSY is ignored.
- FREQ_UPD is asserted only on an actual load (including a reload to the same value in sawtooth). It is never asserted in IDLE.

Decomposition:
- Shared package dds_pkg:
  - MODE encodings (MODE_RAMP, MODE_SAW, MODE_TRI, MODE_TRI1)
  - state encodings (ST_IDLE, ST_HOLD, ST_FINISH)
  - default FW_WIDTH=32
  - reference constant FW_1KHZ=42949 (tuning word for 1 kHz at a 100 MHz clock)
- One natural sub-module: dds_step_clamp. It is combinational and computes the next word with carry/borrow detection and clamping, for both directions.

Test Plan:
1. START_FW=1000, STOP_FW=1300, STEP_FW=100, DWELL=2, MODE=00, START at t0 -> FREQW 1000 (t1-t3), 1100 (t4-t6), 1200 (t7-t9), 1300 (t10-t12); DONE and BUSY=0 at t13; four FREQ_UPD pulses.
2. Same as 1 but STEP_FW=120 -> 1000, 1120, 1240, 1300 (clamped); MODE=01 -> after 1300, FREQW=1000 with FREQ_UPD, BUSY stays 1, no DONE.
3. MODE=11, values as 1 -> 1000, 1100, 1200, 1300, 1200, 1100, 1000, then DONE. MODE=10 -> repeats 1100 upward after 1000.
4. START_FW=0xFFFFFF00, STOP_FW=0xFFFFFFFF, STEP_FW=0x80, DWELL=0 -> FFFFFF00, FFFFFF80, FFFFFFFF (carry clamp), DONE. Descending borrow with START_FW=0x10, STEP_FW=0x80 -> clamps to 0x10.
5. ABORT during the 1200 dwell of test 1 -> next cycle BUSY=0, FREQW stays 1200, no DONE. START and ABORT in the same IDLE cycle -> nothing starts. START while BUSY -> ignored.
6. STEP_FW=0 -> single START_FW dwell then DONE. RST asserted mid-sweep -> FREQW=0 and BUSY=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared encodings and reference constants for the DDS frequency-sweep controller.
package dds_pkg;

    localparam int DDS_FW_WIDTH = 32;
    // Tuning word for 1 kHz at a 100 MHz DDS clock
    localparam int FW_1KHZ      = 42949;

    typedef enum logic [1:0] {
        MODE_RAMP = 2'b00,
        MODE_SAW  = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_TRI1 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HOLD   = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_step_clamp.sv
// Next tuning word for one sweep step, clamped to the sweep limits in either direction.
module dds_step_clamp #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur_fw,
    input  logic [W-1:0] step_fw,
    input  logic [W-1:0] start_fw,
    input  logic [W-1:0] stop_fw,
    input  logic         step_down,
    output logic [W-1:0] next_fw
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Extra MSB carries the overflow (up) or borrow (down)
    assign sum  = {1'b0, cur_fw} + {1'b0, step_fw};
    assign diff = {1'b0, cur_fw} - {1'b0, step_fw};

    always_comb begin
        next_fw = '0;
        if (step_down) begin
            if (diff[W] || (diff[W-1:0] <= start_fw)) next_fw = start_fw;
            else                                      next_fw = diff[W-1:0];
        end else begin
            if (sum[W] || (sum[W-1:0] >= stop_fw)) next_fw = stop_fw;
            else                                   next_fw = sum[W-1:0];
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the DDS tuning word: ramp, sawtooth and triangle sweeps.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_WIDTH    = DDS_FW_WIDTH,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [FW_WIDTH-1:0]    START_FW,
    input  logic [FW_WIDTH-1:0]    STOP_FW,
    input  logic [FW_WIDTH-1:0]    STEP_FW,
    input  logic [DWELL_WIDTH-1:0] DWELL,
    input  logic [1:0]             MODE,
    output logic [FW_WIDTH-1:0]    FREQW,
    output logic                   FREQ_UPD,
    output logic                   BUSY,
    output logic                   DONE
);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [FW_WIDTH-1:0]    start_q, start_d;
    logic [FW_WIDTH-1:0]    stop_q, stop_d;
    logic [FW_WIDTH-1:0]    step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic                   degen_q, degen_d;
    logic                   dir_down_q, dir_down_d;
    logic [FW_WIDTH-1:0]    freqw_q, freqw_d;
    logic                   upd_q, upd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   step_down;
    logic [FW_WIDTH-1:0]    next_fw;

    // Direction of the step about to be taken, including the turn-around at either limit
    assign step_down = dir_down_q ? (freqw_q != start_q) : (freqw_q == stop_q);

    dds_step_clamp #(.W(FW_WIDTH)) u_step (
        .cur_fw    (freqw_q),
        .step_fw   (step_q),
        .start_fw  (start_q),
        .stop_fw   (stop_q),
        .step_down (step_down),
        .next_fw   (next_fw)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        degen_d    = degen_q;
        dir_down_d = dir_down_q;
        freqw_d    = freqw_q;
        upd_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    mode_d     = mode_e'(MODE);
                    start_d    = START_FW;
                    stop_d     = STOP_FW;
                    step_d     = STEP_FW;
                    dwell_d    = DWELL;
                    cnt_d      = DWELL;
                    degen_d    = (STEP_FW == '0) || (STOP_FW <= START_FW);
                    dir_down_d = 1'b0;
                    freqw_d    = START_FW;
                    upd_d      = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (degen_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else if (!dir_down_q && (freqw_q == stop_q)) begin
                        case (mode_q)
                            MODE_RAMP: begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = ST_FINISH;
                            end
                            MODE_SAW: begin
                                freqw_d = start_q;
                                upd_d   = 1'b1;
                            end
                            default: begin
                                dir_down_d = 1'b1;
                                freqw_d    = next_fw;
                                upd_d      = 1'b1;
                            end
                        endcase
                    end else if (dir_down_q && (freqw_q == start_q)) begin
                        if (mode_q == MODE_TRI1) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            dir_down_d = 1'b0;
                            freqw_d    = next_fw;
                            upd_d      = 1'b1;
                        end
                    end else begin
                        freqw_d = next_fw;
                        upd_d   = 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_RAMP;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            degen_q    <= 1'b0;
            dir_down_q <= 1'b0;
            freqw_q    <= '0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            degen_q    <= degen_d;
            dir_down_q <= dir_down_d;
            freqw_q    <= freqw_d;
            upd_q      <= upd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign FREQW    = freqw_q;
    assign FREQ_UPD = upd_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: ramp, saw, triangle, clamping, abort and reset cases.
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic [31:0] START_FW;
    logic [31:0] STOP_FW;
    logic [31:0] STEP_FW;
    logic [23:0] DWELL;
    logic [1:0]  MODE;
    logic [31:0] FREQW;
    logic        FREQ_UPD;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;

    dds_sweep_ctrl #(.FW_WIDTH(32), .DWELL_WIDTH(24)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .ABORT    (ABORT),
        .START_FW (START_FW),
        .STOP_FW  (STOP_FW),
        .STEP_FW  (STEP_FW),
        .DWELL    (DWELL),
        .MODE     (MODE),
        .FREQW    (FREQW),
        .FREQ_UPD (FREQ_UPD),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Pulse START for one cycle, then scramble the config inputs to prove they were latched
    task automatic do_start(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                            input logic [23:0] d, input logic [1:0] m);
        START_FW = s; STOP_FW = p; STEP_FW = st; DWELL = d; MODE = m;
        START = 1'b1;
        tick();
        START    = 1'b0;
        START_FW = 32'h0BAD_0000;
        STOP_FW  = 32'h0000_0007;
        STEP_FW  = 32'h0000_0001;
        DWELL    = 24'd9;
        MODE     = ~m;
    endtask

    // One word held n+1 cycles; FREQ_UPD only in its first cycle
    task automatic check_hold(input logic [31:0] exp, input int n);
        for (int i = 0; i <= n; i++) begin
            chk($sformatf("freqw_%0d_c%0d", exp, i), FREQW, exp);
            chk1($sformatf("upd_%0d_c%0d", exp, i), FREQ_UPD, (i == 0));
            chk1($sformatf("busy_%0d_c%0d", exp, i), BUSY, 1'b1);
            chk1($sformatf("done_%0d_c%0d", exp, i), DONE, 1'b0);
            tick();
        end
    endtask

    task automatic check_done(input logic [31:0] exp);
        chk1("finish_done", DONE, 1'b1);
        chk1("finish_busy", BUSY, 1'b0);
        chk1("finish_upd", FREQ_UPD, 1'b0);
        chk("finish_freqw", FREQW, exp);
        tick();
        chk1("idle_done", DONE, 1'b0);
        chk1("idle_busy", BUSY, 1'b0);
        chk("idle_freqw", FREQW, exp);
    endtask

    task automatic check_aborted(input logic [31:0] exp);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk1("abort_busy", BUSY, 1'b0);
        chk1("abort_done", DONE, 1'b0);
        chk1("abort_upd", FREQ_UPD, 1'b0);
        chk("abort_freqw", FREQW, exp);
        tick();
        chk1("abort_busy_later", BUSY, 1'b0);
        chk1("abort_upd_later", FREQ_UPD, 1'b0);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        START_FW = '0; STOP_FW = '0; STEP_FW = '0; DWELL = '0; MODE = 2'b00;
        #23;
        chk("rst_freqw", FREQW, 32'd0);
        chk1("rst_upd", FREQ_UPD, 1'b0);
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_done", DONE, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        tick();

        // single up-ramp
        do_start(32'd1000, 32'd1300, 32'd100, 24'd2, MODE_RAMP);
        check_hold(32'd1000, 2);
        check_hold(32'd1100, 2);
        check_hold(32'd1200, 2);
        check_hold(32'd1300, 2);
        check_done(32'd1300);

        // clamped last step, ramp then sawtooth
        do_start(32'd1000, 32'd1300, 32'd120, 24'd2, MODE_RAMP);
        check_hold(32'd1000, 2);
        check_hold(32'd1120, 2);
        check_hold(32'd1240, 2);
        check_hold(32'd1300, 2);
        check_done(32'd1300);

        do_start(32'd1000, 32'd1300, 32'd120, 24'd2, MODE_SAW);
        check_hold(32'd1000, 2);
        check_hold(32'd1120, 2);
        check_hold(32'd1240, 2);
        check_hold(32'd1300, 2);
        check_hold(32'd1000, 2);
        check_hold(32'd1120, 2);
        check_aborted(32'd1240);

        // single and continuous triangle
        do_start(32'd1000, 32'd1300, 32'd100, 24'd2, MODE_TRI1);
        check_hold(32'd1000, 2);
        check_hold(32'd1100, 2);
        check_hold(32'd1200, 2);
        check_hold(32'd1300, 2);
        check_hold(32'd1200, 2);
        check_hold(32'd1100, 2);
        check_hold(32'd1000, 2);
        check_done(32'd1000);

        do_start(32'd1000, 32'd1300, 32'd100, 24'd1, MODE_TRI);
        check_hold(32'd1000, 1);
        check_hold(32'd1100, 1);
        check_hold(32'd1200, 1);
        check_hold(32'd1300, 1);
        check_hold(32'd1200, 1);
        check_hold(32'd1100, 1);
        check_hold(32'd1000, 1);
        check_hold(32'd1100, 1);
        check_hold(32'd1200, 1);
        check_aborted(32'd1300);

        // carry clamp at the top of the range
        do_start(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0, MODE_RAMP);
        check_hold(32'hFFFF_FF00, 0);
        check_hold(32'hFFFF_FF80, 0);
        check_hold(32'hFFFF_FFFF, 0);
        check_done(32'hFFFF_FFFF);

        // borrow clamp on the way down
        do_start(32'h10, 32'h50, 32'h80, 24'd0, MODE_TRI1);
        check_hold(32'h10, 0);
        check_hold(32'h50, 0);
        check_hold(32'h10, 0);
        check_done(32'h10);

        // START while busy is ignored, then ABORT mid-dwell
        do_start(32'd1000, 32'd1300, 32'd100, 24'd2, MODE_RAMP);
        check_hold(32'd1000, 2);
        chk("busy_start_fw0", FREQW, 32'd1100);
        START_FW = 32'd5; STOP_FW = 32'd9000; STEP_FW = 32'd7; DWELL = 24'd0; MODE = MODE_SAW;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_start_fw1", FREQW, 32'd1100);
        chk1("busy_start_upd1", FREQ_UPD, 1'b0);
        tick();
        chk("busy_start_fw2", FREQW, 32'd1100);
        tick();
        chk("busy_start_next", FREQW, 32'd1200);
        chk1("busy_start_next_upd", FREQ_UPD, 1'b1);
        check_aborted(32'd1200);

        // START and ABORT together in IDLE: nothing starts
        START_FW = 32'd1000; STOP_FW = 32'd1300; STEP_FW = 32'd100; DWELL = 24'd2; MODE = MODE_RAMP;
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk1("startabort_busy", BUSY, 1'b0);
        chk1("startabort_upd", FREQ_UPD, 1'b0);
        chk("startabort_freqw", FREQW, 32'd1200);
        tick();
        chk1("startabort_busy_later", BUSY, 1'b0);

        // degenerate configurations finish after one dwell in every mode
        do_start(32'd1000, 32'd1300, 32'd0, 24'd1, MODE_SAW);
        check_hold(32'd1000, 1);
        check_done(32'd1000);

        do_start(32'd500, 32'd400, 32'd10, 24'd0, MODE_TRI);
        check_hold(32'd500, 0);
        check_done(32'd500);

        // asynchronous reset mid-sweep
        do_start(32'd1000, 32'd1300, 32'd100, 24'd2, MODE_RAMP);
        check_hold(32'd1000, 2);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_freqw", FREQW, 32'd0);
        chk1("arst_busy", BUSY, 1'b0);
        chk1("arst_upd", FREQ_UPD, 1'b0);
        chk1("arst_done", DONE, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        tick();
        chk("post_rst_freqw", FREQW, 32'd0);
        chk1("post_rst_busy", BUSY, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
